// File: rtl/pitch_freq_module.sv
// Pitch-to-frequency converter. It takes min_tau lag results and rejects lags
// outside [MIN_TAU, MAX_TAU]. Valid lags are median-of-3 filtered. The filtered
// lag is turned into a rounded frequency (SAMPLE_RATE + m/2) / m by a serial
// restoring divider. Each new freq/voiced value is marked by a one-cycle strobe.
module pitch_freq_module #(
   parameter int TAU_WIDTH   = 8,
   parameter int MIN_TAU     = 2,
   parameter int MAX_TAU     = 40,
   parameter int SAMPLE_RATE = 20000,
   parameter int FREQ_WIDTH  = 16,
   parameter int HOLD_COUNT  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tau_valid,
   input  logic [TAU_WIDTH-1:0]  tau,
   output logic [FREQ_WIDTH-1:0] freq,
   output logic                  freq_valid,
   output logic                  voiced,
   output logic                  busy,
   output logic                  overrun
);

   localparam int MW = (HOLD_COUNT < 2) ? 1 : $clog2(HOLD_COUNT + 1);
   localparam int CW = (FREQ_WIDTH < 2) ? 1 : $clog2(FREQ_WIDTH);
   localparam logic [CW-1:0]        LAST_BIT = CW'(FREQ_WIDTH - 1);
   localparam logic [MW-1:0]        HOLD     = MW'(HOLD_COUNT);
   localparam logic [TAU_WIDTH-1:0] LO_TAU   = TAU_WIDTH'(MIN_TAU);
   localparam logic [TAU_WIDTH-1:0] HI_TAU   = TAU_WIDTH'(MAX_TAU);

   typedef enum logic [1:0] {IDLE, FILTER, DIVIDE, DONE} state_t;

   state_t                state;
   logic [TAU_WIDTH-1:0]  tau_r;
   logic [TAU_WIDTH-1:0]  h0, h1;    // h0 newest; only two old entries feed the median
   logic [1:0]            hcnt;
   logic [MW-1:0]         miss;
   logic [FREQ_WIDTH-1:0] dvd, dvs, quo;
   logic [FREQ_WIDTH:0]   rem;
   logic [CW-1:0]         cnt;

   logic                  in_range;
   logic [TAU_WIDTH-1:0]  lo, hi, hi_c, med, m;
   logic [MW-1:0]         miss_inc;
   logic [FREQ_WIDTH:0]   rem_sh, rem_nx;
   logic                  fits;

   // Lag classification, median selection and one restoring-divide step
   always_comb begin
      in_range = (tau_r >= LO_TAU) && (tau_r <= HI_TAU);
      lo       = (tau_r < h0) ? tau_r : h0;
      hi       = (tau_r < h0) ? h0 : tau_r;
      hi_c     = (hi < h1) ? hi : h1;
      med      = (lo > hi_c) ? lo : hi_c;
      // With two entries already held, the new one completes a full window
      m        = (hcnt >= 2'd2) ? med : tau_r;
      miss_inc = (miss == HOLD) ? miss : miss + 1'b1;
      rem_sh   = {rem[FREQ_WIDTH-1:0], dvd[FREQ_WIDTH-1]};
      fits     = (rem_sh >= {1'b0, dvs});
      rem_nx   = fits ? (rem_sh - {1'b0, dvs}) : rem_sh;
   end

   assign busy = (state != IDLE);

   // Control FSM, filter history, divider datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         tau_r      <= '0;
         h0         <= '0;
         h1         <= '0;
         hcnt       <= '0;
         miss       <= '0;
         dvd        <= '0;
         dvs        <= '0;
         quo        <= '0;
         rem        <= '0;
         cnt        <= '0;
         freq       <= '0;
         freq_valid <= 1'b0;
         voiced     <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         freq_valid <= (state == DONE);
         overrun    <= tau_valid && (state != IDLE);
         case (state)
            IDLE: begin
               if (tau_valid) begin
                  tau_r <= tau;
                  state <= FILTER;
               end
            end
            FILTER: begin
               if (in_range) begin
                  h0   <= tau_r;
                  h1   <= h0;
                  hcnt <= (hcnt == 2'd3) ? hcnt : hcnt + 2'd1;
                  miss <= '0;
                  dvd  <= FREQ_WIDTH'(SAMPLE_RATE) + FREQ_WIDTH'(m >> 1);
                  dvs  <= FREQ_WIDTH'(m);
                  rem  <= '0;
                  quo  <= '0;
                  cnt  <= '0;
                  state <= DIVIDE;
               end else begin
                  miss <= miss_inc;
                  if (miss_inc == HOLD) begin
                     freq   <= '0;
                     voiced <= 1'b0;
                     hcnt   <= '0;
                     h0     <= '0;
                     h1     <= '0;
                  end
                  state <= DONE;
               end
            end
            DIVIDE: begin
               rem <= rem_nx;
               dvd <= dvd << 1;
               quo <= {quo[FREQ_WIDTH-2:0], fits};
               cnt <= cnt + 1'b1;
               if (cnt == LAST_BIT) begin
                  freq   <= {quo[FREQ_WIDTH-2:0], fits};
                  voiced <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
